// File: rtl/hc_c1_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hc_c1_wr_arbiter : CCI-P channel-1 write arbiter (stream writeback A, DSM  |
// |                    writes B) with credit/almost-full gating and DSM drain. |
// | Optional: define HC_WR_ARB_STATS_EN for write/throttle statistics ports.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module hc_c1_wr_arbiter_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);
  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (i_push) r_wptr <= ~r_wptr;
      if (i_pop)  r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  assign o_full  = (r_cnt == 2'd2);
  assign o_empty = (r_cnt == 2'd0);
  assign o_head  = r_mem[r_rptr];
endmodule

module hc_c1_wr_arbiter #(
  parameter int MAX_OUTSTANDING = 64,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [41:0]      a_addr,
  input  logic [511:0]     a_data,
  input  logic [15:0]      a_mdata,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [41:0]      b_addr,
  input  logic [511:0]     b_data,
  input  logic [15:0]      b_mdata,
  input  logic             c1_alm_full,
  output logic             c1_tx_valid,
  output logic [41:0]      c1_tx_addr,
  output logic [511:0]     c1_tx_data,
  output logic [15:0]      c1_tx_mdata,
  input  logic             c1_rx_wr_rsp,
  output logic [CNT_W-1:0] outstanding,
  output logic             idle,
  output logic             err_underflow
`ifdef HC_WR_ARB_STATS_EN
  ,
  output logic [31:0]      stat_a_wr,
  output logic [31:0]      stat_b_wr,
  output logic [31:0]      stat_throttle
`endif
);
  localparam int               c_w      = 42 + 512 + 16;
  localparam logic [CNT_W:0]   c_max    = (CNT_W+1)'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);
  localparam logic [1:0]       S_ARB     = 2'd0;
  localparam logic [1:0]       S_DRAIN   = 2'd1;
  localparam logic [1:0]       S_ISSUE_B = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_rr_last_b;
  logic             r_run;
  logic             r_tx_valid;
  logic [c_w-1:0]   r_tx;
  logic [CNT_W-1:0] r_out;
  logic             r_err;

  logic             w_a_push, w_a_full, w_a_empty;
  logic             w_b_push, w_b_full, w_b_empty;
  logic [c_w-1:0]   w_a_head, w_b_head;
  logic             w_grant_a, w_grant_b, w_grant;
  logic             w_can_issue;
  logic             w_arb_drain;
  logic             w_arb_a;
  logic [CNT_W:0]   w_inflight;

  // Ready is held low until the first clock after reset release.
  assign a_ready  = r_run && !w_a_full;
  assign b_ready  = r_run && !w_b_full;
  assign w_a_push = a_valid && a_ready;
  assign w_b_push = b_valid && b_ready;

  hc_c1_wr_arbiter_fifo2 #(.W(c_w)) u_fifo_a (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_a_push),
    .i_data  ({a_addr, a_data, a_mdata}),
    .i_pop   (w_grant_a),
    .o_full  (w_a_full),
    .o_empty (w_a_empty),
    .o_head  (w_a_head)
  );

  hc_c1_wr_arbiter_fifo2 #(.W(c_w)) u_fifo_b (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_b_push),
    .i_data  ({b_addr, b_data, b_mdata}),
    .i_pop   (w_grant_b),
    .o_full  (w_b_full),
    .o_empty (w_b_empty),
    .o_head  (w_b_head)
  );

  // The write sitting in the output register already holds a credit.
  assign w_inflight  = {1'b0, r_out} + {{CNT_W{1'b0}}, r_tx_valid};
  assign w_can_issue = !c1_alm_full && (w_inflight < c_max);

  // Right after a B write, a waiting A head gets one turn before B drains again.
  assign w_arb_drain = !w_b_empty && !(r_rr_last_b && !w_a_empty);
  assign w_arb_a     = !w_arb_drain && !w_a_empty;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_a   = 1'b0;
    w_grant_b   = 1'b0;
    case (r_state)
      S_ARB: begin
        if (w_arb_drain)  w_state_nxt = S_DRAIN;
        else if (w_arb_a) w_grant_a   = w_can_issue;
      end
      S_DRAIN: begin
        if ((r_out == '0) && !r_tx_valid && !c1_rx_wr_rsp) w_state_nxt = S_ISSUE_B;
      end
      S_ISSUE_B: begin
        if (w_b_empty) begin
          w_state_nxt = S_ARB;
        end else if (w_can_issue) begin
          w_grant_b   = 1'b1;
          w_state_nxt = S_ARB;
        end
      end
      default: w_state_nxt = S_ARB;
    endcase
  end

  assign w_grant = w_grant_a || w_grant_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_ARB;
      r_rr_last_b <= 1'b1;
      r_run       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= 1'b1;
      if (w_grant_a)      r_rr_last_b <= 1'b0;
      else if (w_grant_b) r_rr_last_b <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_valid <= 1'b0;
      r_tx       <= '0;
    end else begin
      r_tx_valid <= w_grant;
      if (w_grant) r_tx <= w_grant_b ? w_b_head : w_a_head;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out <= '0;
      r_err <= 1'b0;
    end else if (r_tx_valid && !c1_rx_wr_rsp) begin
      r_out <= r_out + c_one;
    end else if (!r_tx_valid && c1_rx_wr_rsp) begin
      if (r_out == '0) r_err <= 1'b1;
      else             r_out <= r_out - c_one;
    end
  end

  assign c1_tx_valid   = r_tx_valid;
  assign c1_tx_addr    = r_tx[c_w-1 -: 42];
  assign c1_tx_data    = r_tx[16 +: 512];
  assign c1_tx_mdata   = r_tx[15:0];
  assign outstanding   = r_out;
  assign err_underflow = r_err;
  assign idle          = w_a_empty && w_b_empty && !r_tx_valid && (r_out == '0);

`ifdef HC_WR_ARB_STATS_EN
  logic [31:0] r_stat_a, r_stat_b, r_stat_thr;
  logic        w_stall;

  assign w_stall = !w_can_issue &&
                   (((r_state == S_ARB) && w_arb_a) || ((r_state == S_ISSUE_B) && !w_b_empty));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_a   <= '0;
      r_stat_b   <= '0;
      r_stat_thr <= '0;
    end else begin
      if (w_grant_a && (r_stat_a != '1))   r_stat_a   <= r_stat_a + 32'd1;
      if (w_grant_b && (r_stat_b != '1))   r_stat_b   <= r_stat_b + 32'd1;
      if (w_stall && (r_stat_thr != '1))   r_stat_thr <= r_stat_thr + 32'd1;
    end
  end

  assign stat_a_wr     = r_stat_a;
  assign stat_b_wr     = r_stat_b;
  assign stat_throttle = r_stat_thr;
`endif
endmodule
`default_nettype wire

// File: tb/tb_hc_c1_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hc_c1_wr_arbiter : scoreboard bench for hc_c1_wr_arbiter                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_hc_c1_wr_arbiter;
  localparam int MAXO = 4;
  localparam int CW   = $clog2(MAXO) + 1;

  typedef struct {
    logic [41:0]  addr;
    logic [511:0] data;
    logic [15:0]  mdata;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic          a_ready, b_ready;
  logic [41:0]   a_addr = '0, b_addr = '0;
  logic [511:0]  a_data = '0, b_data = '0;
  logic [15:0]   a_mdata = '0, b_mdata = '0;
  logic          c1_alm_full = 1'b0;
  logic          c1_tx_valid;
  logic [41:0]   c1_tx_addr;
  logic [511:0]  c1_tx_data;
  logic [15:0]   c1_tx_mdata;
  logic          c1_rx_wr_rsp;
  logic [CW-1:0] outstanding;
  logic          idle, err_underflow;
`ifdef HC_WR_ARB_STATS_EN
  logic [31:0]   stat_a_wr, stat_b_wr, stat_throttle;
  logic [31:0]   thr0;
`endif

  beat_t aq[$], bq[$], exp_q[$];
  beat_t mon_e;
  int    rsp_due[$];
  int    checks = 0, failures = 0;
  int    tx_count = 0, peak = 0, cyc = 0, base = 0;
  bit    auto_rsp = 1'b0;
  bit    a_acc, b_acc;
  logic  rsp_auto = 1'b0, rsp_man = 1'b0;

  assign c1_rx_wr_rsp = rsp_auto | rsp_man;

  always #5 clk = ~clk;

  hc_c1_wr_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .a_valid       (a_valid),
    .a_ready       (a_ready),
    .a_addr        (a_addr),
    .a_data        (a_data),
    .a_mdata       (a_mdata),
    .b_valid       (b_valid),
    .b_ready       (b_ready),
    .b_addr        (b_addr),
    .b_data        (b_data),
    .b_mdata       (b_mdata),
    .c1_alm_full   (c1_alm_full),
    .c1_tx_valid   (c1_tx_valid),
    .c1_tx_addr    (c1_tx_addr),
    .c1_tx_data    (c1_tx_data),
    .c1_tx_mdata   (c1_tx_mdata),
    .c1_rx_wr_rsp  (c1_rx_wr_rsp),
    .outstanding   (outstanding),
    .idle          (idle),
    .err_underflow (err_underflow)
`ifdef HC_WR_ARB_STATS_EN
    ,
    .stat_a_wr     (stat_a_wr),
    .stat_b_wr     (stat_b_wr),
    .stat_throttle (stat_throttle)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic beat_t mk(input logic [41:0] addr);
    beat_t b;
    b.addr  = addr;
    b.data  = {16{addr[31:0] ^ 32'hC0DE_0000}};
    b.mdata = addr[15:0] ^ 16'h5A5A;
    return b;
  endfunction

  task automatic push_a(input logic [41:0] addr, input bit expect_tx);
    aq.push_back(mk(addr));
    if (expect_tx) exp_q.push_back(mk(addr));
  endtask

  task automatic push_b(input logic [41:0] addr, input bit expect_tx);
    bq.push_back(mk(addr));
    if (expect_tx) exp_q.push_back(mk(addr));
  endtask

  task automatic pulse_rsp();
    @(posedge clk); #1 rsp_man = 1'b1;
    @(posedge clk); #1 rsp_man = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int budget, input string name);
    int k = 0;
    while (tx_count < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk(name, 64'(tx_count), 64'(n));
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (idle !== 1'b1 && k < budget);
    chk(name, 64'(idle), 64'd1);
  endtask

  always @(posedge clk) cyc++;

  // Requester drivers: present queue heads, retire on observed handshake.
  always begin
    @(negedge clk);
    a_acc = a_valid && a_ready;
    b_acc = b_valid && b_ready;
    @(posedge clk);
    #1;
    if (a_acc && aq.size() > 0) void'(aq.pop_front());
    if (b_acc && bq.size() > 0) void'(bq.pop_front());
    if (aq.size() > 0) begin
      a_valid = 1'b1; a_addr = aq[0].addr; a_data = aq[0].data; a_mdata = aq[0].mdata;
    end else a_valid = 1'b0;
    if (bq.size() > 0) begin
      b_valid = 1'b1; b_addr = bq[0].addr; b_data = bq[0].data; b_mdata = bq[0].mdata;
    end else b_valid = 1'b0;
  end

  // Auto responder: one response per cycle, five cycles after each write.
  always @(posedge clk) begin
    #1;
    if (rsp_due.size() > 0 && rsp_due[0] <= cyc) begin
      rsp_auto = 1'b1;
      void'(rsp_due.pop_front());
    end else rsp_auto = 1'b0;
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (reset_n && int'(outstanding) > peak) peak = int'(outstanding);
    if (c1_tx_valid === 1'b1) begin
      tx_count++;
      if (auto_rsp) rsp_due.push_back(cyc + 5);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_tx: got addr 0x%0h, expected no write", c1_tx_addr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("tx_addr", 64'(c1_tx_addr), 64'(mon_e.addr));
        chk("tx_mdata", 64'(c1_tx_mdata), 64'(mon_e.mdata));
        chk("tx_data_match", 64'(c1_tx_data == mon_e.data), 64'd1);
        if (mon_e.addr == 42'h200) chk("dsm_b_after_drain", 64'(outstanding), 64'd0);
      end
    end
  end

  initial begin
    #1 reset_n = 1'b0;
    #1;
    chk("rst_a_ready", 64'(a_ready), 64'd0);
    chk("rst_b_ready", 64'(b_ready), 64'd0);
    chk("rst_tx_valid", 64'(c1_tx_valid), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_err", 64'(err_underflow), 64'd0);
`ifdef HC_WR_ARB_STATS_EN
    chk("rst_stat_throttle", 64'(stat_throttle), 64'd0);
`endif
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_a_ready", 64'(a_ready), 64'd1);
    chk("post_rst_b_ready", 64'(b_ready), 64'd1);

    // A-only burst
    auto_rsp = 1'b1; peak = 0; base = tx_count;
    for (int i = 0; i < 10; i++) push_a(42'h100 + 42'(i), 1'b1);
    wait_tx(base + 10, 300, "burst_tx_count");
    wait_idle(100, "burst_idle");
    chk("burst_peak_le_max", 64'(peak <= MAXO), 64'd1);
    chk("burst_outstanding_zero", 64'(outstanding), 64'd0);

    // Credit limit with withheld responses
    auto_rsp = 1'b0; base = tx_count;
    for (int i = 0; i < 8; i++) push_a(42'h180 + 42'(i), 1'b1);
    repeat (20) @(posedge clk);
    chk("credit_stall_tx", 64'(tx_count - base), 64'd4);
    chk("credit_outstanding_full", 64'(outstanding), 64'd4);
    pulse_rsp();
    repeat (5) @(posedge clk);
    chk("credit_release_one", 64'(tx_count - base), 64'd5);
    pulse_rsp();
    begin
      int k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!(c1_tx_valid === 1'b1 && outstanding == 3) && k < 10);
      chk("concur_setup", 64'(c1_tx_valid === 1'b1 && outstanding == 3), 64'd1);
    end
    rsp_man = 1'b1;
    @(posedge clk); #1 rsp_man = 1'b0;
    chk("concur_same_cycle", 64'(outstanding), 64'd3);
    repeat (5) @(posedge clk);
    chk("credit_after_concur", 64'(tx_count - base), 64'd7);
    pulse_rsp();
    repeat (5) @(posedge clk);
    chk("credit_last_release", 64'(tx_count - base), 64'd8);
    for (int i = 0; i < 4; i++) begin
      pulse_rsp();
      repeat (2) @(posedge clk);
    end
    wait_idle(20, "credit_idle");

    // Underflow
    pulse_rsp();
    @(negedge clk);
    chk("underflow_flag", 64'(err_underflow), 64'd1);
    chk("underflow_count_zero", 64'(outstanding), 64'd0);

    // Almost-full throttle
    auto_rsp = 1'b1; base = tx_count;
    @(posedge clk); #1 c1_alm_full = 1'b1;
    push_a(42'h400, 1'b1);
    push_a(42'h401, 1'b1);
    begin
      int k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (aq.size() > 0 && k < 10);
    end
    @(posedge clk); #1;
`ifdef HC_WR_ARB_STATS_EN
    thr0 = stat_throttle;
`endif
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("throttle_no_tx", 64'(c1_tx_valid), 64'd0);
    end
    c1_alm_full = 1'b0;
`ifdef HC_WR_ARB_STATS_EN
    chk("stat_throttle_delta", 64'(stat_throttle - thr0), 64'd6);
`endif
    @(posedge clk); #1;
    chk("throttle_resume", 64'(c1_tx_valid), 64'd1);
    wait_tx(base + 2, 10, "throttle_tx_count");
    wait_idle(30, "throttle_idle");

    // DSM ordering
    auto_rsp = 1'b0; base = tx_count;
    for (int i = 0; i < 3; i++) push_a(42'h300 + 42'(i), 1'b1);
    wait_tx(base + 3, 20, "dsm_a_issued");
    @(negedge clk);
    chk("dsm_a_outstanding", 64'(outstanding), 64'd3);
    push_b(42'h200, 1'b1);
    push_a(42'h303, 1'b1);
    repeat (10) @(posedge clk);
    chk("dsm_b_held", 64'(tx_count - base), 64'd3);
    for (int i = 0; i < 3; i++) begin
      pulse_rsp();
      repeat (2) @(posedge clk);
    end
    wait_tx(base + 5, 20, "dsm_all_issued");
    for (int i = 0; i < 2; i++) begin
      pulse_rsp();
      repeat (2) @(posedge clk);
    end
    wait_idle(20, "dsm_idle");

    // Async reset with both FIFOs full
    c1_alm_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_a(42'h500 + 42'(i), 1'b0);
      push_b(42'h580 + 42'(i), 1'b0);
    end
    begin
      int k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!(a_ready === 1'b0 && b_ready === 1'b0) && k < 10);
      chk("rst_fifos_full", 64'(a_ready === 1'b0 && b_ready === 1'b0), 64'd1);
    end
    @(posedge clk); #3;
    reset_n = 1'b0;
    aq.delete(); bq.delete(); rsp_due.delete();
    c1_alm_full = 1'b0;
    #1;
    chk("midrst_a_ready", 64'(a_ready), 64'd0);
    chk("midrst_b_ready", 64'(b_ready), 64'd0);
    chk("midrst_tx_valid", 64'(c1_tx_valid), 64'd0);
    chk("midrst_outstanding", 64'(outstanding), 64'd0);
    chk("midrst_idle", 64'(idle), 64'd1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_a_ready", 64'(a_ready), 64'd1);
    chk("rel_b_ready", 64'(b_ready), 64'd1);
    chk("rel_err_cleared", 64'(err_underflow), 64'd0);
    auto_rsp = 1'b1; base = tx_count;
    push_a(42'h600, 1'b1);
    wait_tx(base + 1, 5, "rel_first_issue");
    wait_idle(20, "final_idle");
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
